// File: rtl/core_dbg_pkg.sv
// Shared types and sizes for the core run/halt/step/dump controller.
package core_dbg_pkg;

  localparam int REG_CNT   = 32;
  localparam int DBG_SEL_W = 5;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    DUMP = 2'd3
  } state_t;

endpackage

// File: rtl/reg_dump_seq.sv
// Register-file dump sequencer: walks the debug read index and emits one
// registered beat per register over a valid/ready port (1 beat / 2 cycles).
module reg_dump_seq
  import core_dbg_pkg::*;
#(
  parameter int DUMP_REGS = REG_CNT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 start,
  input  logic                 done,
  input  logic [31:0]          rd_data,
  input  logic                 ready,
  output logic [DBG_SEL_W-1:0] sel,
  output logic [31:0]          data,
  output logic                 valid,
  output logic                 last
);

  localparam logic [DBG_SEL_W-1:0] LAST_IDX = DBG_SEL_W'(DUMP_REGS - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel   <= '0;
      data  <= '0;
      valid <= 1'b0;
      last  <= 1'b0;
    end else if (start) begin
      sel <= '0;
    end else if (en) begin
      if (!valid) begin
        data  <= rd_data;
        valid <= 1'b1;
        last  <= (sel == LAST_IDX);
      end else if (ready) begin
        valid <= 1'b0;
        if (done) begin
          sel  <= '0;
          last <= 1'b0;
        end else begin
          sel <= sel + DBG_SEL_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/core_run_controller.sv
// Run/halt/single-step controller with halted-state register dump.
// Optional breakpoint stop is built when CRC_BREAKPOINT_EN is defined.
module core_run_controller
  import core_dbg_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int DUMP_REGS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run_req,
  input  logic                 halt_req,
  input  logic                 step_req,
  input  logic                 dump_req,
  input  logic [31:0]          PC,
  input  logic [31:0]          Debug_out,
  output logic [DBG_SEL_W-1:0] Debug_Source_select,
  output logic                 core_en,
  output logic [31:0]          dump_data,
  output logic                 dump_valid,
  input  logic                 dump_ready,
  output logic                 dump_last,
  output logic                 halted,
  output logic [CNT_W-1:0]     instr_count
`ifdef CRC_BREAKPOINT_EN
  ,
  input  logic [31:0]          bp_addr,
  output logic                 bp_hit
`endif
);

  state_t state;
  logic   bp_stop;
  logic   step_go, run_go, dump_go, dump_done;

  // Requests seen in HALT, resolved by priority halt > step > run > dump.
  assign step_go   = (state == HALT) && !halt_req && step_req;
  assign run_go    = (state == HALT) && !halt_req && !step_req && run_req;
  assign dump_go   = (state == HALT) && !halt_req && !step_req && !run_req && dump_req;
  assign dump_done = (state == DUMP) && dump_valid && dump_ready && dump_last;

  assign core_en = ((state == RUN) && !bp_stop) || (state == STEP);
  assign halted  = (state == HALT);

`ifdef CRC_BREAKPOINT_EN
  logic first_run;

  // The first RUN cycle never stops, so resuming from bp_addr executes it.
  assign bp_stop = (state == RUN) && (PC == bp_addr) && !first_run;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first_run <= 1'b0;
      bp_hit    <= 1'b0;
    end else begin
      first_run <= run_go;
      if (bp_stop)
        bp_hit <= 1'b1;
      else if (run_go || step_go)
        bp_hit <= 1'b0;
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^PC;
  assign bp_stop   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= HALT;
      instr_count <= '0;
    end else begin
      if (core_en)
        instr_count <= instr_count + CNT_W'(1);
      case (state)
        HALT: begin
          if (step_go)      state <= STEP;
          else if (run_go)  state <= RUN;
          else if (dump_go) state <= DUMP;
        end
        RUN:     if (halt_req || bp_stop) state <= HALT;
        STEP:    state <= HALT;
        DUMP:    if (dump_done) state <= HALT;
        default: state <= HALT;
      endcase
    end
  end

  reg_dump_seq #(.DUMP_REGS(DUMP_REGS)) u_dump (
    .clk     (clk),
    .reset   (reset),
    .en      (state == DUMP),
    .start   (dump_go),
    .done    (dump_done),
    .rd_data (Debug_out),
    .ready   (dump_ready),
    .sel     (Debug_Source_select),
    .data    (dump_data),
    .valid   (dump_valid),
    .last    (dump_last)
  );

endmodule

// File: tb/tb_core_run_controller.sv
// Bench for core_run_controller: behavioural model of retired-instruction
// count, PC progression and dump beat stream, with randomized stimulus.
module tb_core_run_controller;
  import core_dbg_pkg::*;

  localparam int CNT_W     = 32;
  localparam int DUMP_REGS = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              run_req = 1'b0, halt_req = 1'b0, step_req = 1'b0, dump_req = 1'b0;
  logic              dump_ready = 1'b0;
  logic [31:0]       pc, dbg_base, Debug_out, dump_data;
  logic [4:0]        sel;
  logic              core_en, dump_valid, dump_last, halted;
  logic [CNT_W-1:0]  instr_count;
`ifdef CRC_BREAKPOINT_EN
  logic [31:0]       bp_addr = 32'hFFFF_FFF0;
  logic              bp_hit;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int en_hi    = 0;
  logic [CNT_W-1:0] exp_count = '0;

  core_run_controller #(.CNT_W(CNT_W), .DUMP_REGS(DUMP_REGS)) dut (
    .clk                 (clk),
    .reset               (rst_n),
    .run_req             (run_req),
    .halt_req            (halt_req),
    .step_req            (step_req),
    .dump_req            (dump_req),
    .PC                  (pc),
    .Debug_out           (Debug_out),
    .Debug_Source_select (sel),
    .core_en             (core_en),
    .dump_data           (dump_data),
    .dump_valid          (dump_valid),
    .dump_ready          (dump_ready),
    .dump_last           (dump_last),
    .halted              (halted),
    .instr_count         (instr_count)
`ifdef CRC_BREAKPOINT_EN
    ,
    .bp_addr             (bp_addr),
    .bp_hit              (bp_hit)
`endif
  );

  always #5 clk = ~clk;

  // Datapath stand-in: PC advances one word per enabled cycle.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= 32'h0;
    else if (core_en) pc <= pc + 32'd4;

  assign Debug_out = dbg_base + 32'(sel);

  always @(negedge clk) if (core_en) en_hi++;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks += 7;
    if (core_en !== 1'b0)     begin n_fail++; $display("FAIL reset_core_en: got %b exp 0", core_en); end
    if (halted !== 1'b1)      begin n_fail++; $display("FAIL reset_halted: got %b exp 1", halted); end
    if (sel !== 5'd0)         begin n_fail++; $display("FAIL reset_sel: got %0d exp 0", sel); end
    if (dump_data !== 32'h0)  begin n_fail++; $display("FAIL reset_data: got %h exp 0", dump_data); end
    if (dump_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %b exp 0", dump_valid); end
    if (dump_last !== 1'b0)   begin n_fail++; $display("FAIL reset_last: got %b exp 0", dump_last); end
    if (instr_count !== '0)   begin n_fail++; $display("FAIL reset_count: got %0d exp 0", instr_count); end
`ifdef CRC_BREAKPOINT_EN
    n_checks++;
    if (bp_hit !== 1'b0)      begin n_fail++; $display("FAIL reset_bp_hit: got %b exp 0", bp_hit); end
`endif
    @(negedge clk) rst_n = 1'b1;
    exp_count = '0;
    tick();
  endtask

  task automatic test_step();
    int e0;
    for (int k = 0; k < 2; k++) begin
      e0 = en_hi;
      step_req = 1'b1; tick(); step_req = 1'b0;
      repeat (3) @(negedge clk);
      exp_count = exp_count + 1;
      n_checks += 3;
      if (en_hi - e0 != 1)          begin n_fail++; $display("FAIL step_en_cycles: got %0d exp 1", en_hi - e0); end
      if (instr_count !== exp_count) begin n_fail++; $display("FAIL step_count: got %0d exp %0d", instr_count, exp_count); end
      if (halted !== 1'b1)          begin n_fail++; $display("FAIL step_halted: got %b exp 1", halted); end
      tick();
    end
  endtask

  task automatic test_run(input int n);
    int e0;
    e0 = en_hi;
    run_req = 1'b1; tick(); run_req = 1'b0;
    repeat (n) begin
      step_req = 1'($urandom); dump_req = 1'($urandom);
      tick();
    end
    step_req = 1'b0; dump_req = 1'b0;
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    @(negedge clk);
    exp_count = exp_count + CNT_W'(n + 1);
    n_checks += 4;
    if (core_en !== 1'b0)          begin n_fail++; $display("FAIL run_core_en_after: got %b exp 0", core_en); end
    if (halted !== 1'b1)           begin n_fail++; $display("FAIL run_halted: got %b exp 1", halted); end
    if (instr_count !== exp_count) begin n_fail++; $display("FAIL run_count: got %0d exp %0d", instr_count, exp_count); end
    if (en_hi - e0 != n + 1)       begin n_fail++; $display("FAIL run_en_cycles: got %0d exp %0d", en_hi - e0, n + 1); end
    tick();
  endtask

  task automatic test_priority();
    int e0;
    e0 = en_hi;
    halt_req = 1'b1; step_req = 1'b1; run_req = 1'b1; dump_req = 1'b1;
    tick();
    halt_req = 1'b0; step_req = 1'b0; run_req = 1'b0; dump_req = 1'b0;
    repeat (2) @(negedge clk);
    n_checks += 3;
    if (halted !== 1'b1)           begin n_fail++; $display("FAIL prio_all_halted: got %b exp 1", halted); end
    if (en_hi != e0)               begin n_fail++; $display("FAIL prio_all_en: got %0d exp 0", en_hi - e0); end
    if (dump_valid !== 1'b0)       begin n_fail++; $display("FAIL prio_all_no_dump: got %b exp 0", dump_valid); end
    // step beats run: exactly one instruction
    tick();
    e0 = en_hi;
    step_req = 1'b1; run_req = 1'b1; tick(); step_req = 1'b0; run_req = 1'b0;
    repeat (3) @(negedge clk);
    exp_count = exp_count + 1;
    n_checks += 2;
    if (en_hi - e0 != 1)           begin n_fail++; $display("FAIL prio_step_run_en: got %0d exp 1", en_hi - e0); end
    if (instr_count !== exp_count) begin n_fail++; $display("FAIL prio_step_run_count: got %0d exp %0d", instr_count, exp_count); end
    // run beats dump
    tick();
    run_req = 1'b1; dump_req = 1'b1; tick(); run_req = 1'b0; dump_req = 1'b0;
    halt_req = 1'b1;
    @(negedge clk);
    n_checks += 2;
    if (core_en !== 1'b1)          begin n_fail++; $display("FAIL prio_run_dump_en: got %b exp 1", core_en); end
    if (dump_valid !== 1'b0)       begin n_fail++; $display("FAIL prio_run_dump_valid: got %b exp 0", dump_valid); end
    tick(); halt_req = 1'b0;
    exp_count = exp_count + 1;
    @(negedge clk);
    n_checks++;
    if (instr_count !== exp_count) begin n_fail++; $display("FAIL prio_run_dump_count: got %0d exp %0d", instr_count, exp_count); end
    tick();
  endtask

  task automatic test_dump(input logic [31:0] base);
    int e0, beats, cyc;
    logic stalled, held_last;
    logic [31:0] held_data;
    e0 = en_hi; beats = 0; cyc = 0; stalled = 1'b0; held_last = 1'b0; held_data = '0;
    dbg_base = base;
    dump_req = 1'b1; tick(); dump_req = 1'b0;
    while (beats < DUMP_REGS && cyc < 400) begin
      dump_ready = 1'($urandom);
      if (beats < DUMP_REGS - 1) begin
        halt_req = 1'($urandom); run_req = 1'($urandom); step_req = 1'($urandom);
      end else begin
        halt_req = 1'b0; run_req = 1'b0; step_req = 1'b0;
      end
      @(negedge clk);
      if (dump_valid) begin
        if (stalled) begin
          n_checks++;
          if (dump_data !== held_data || dump_last !== held_last) begin
            n_fail++; $display("FAIL dump_stall_stable: got %h/%b exp %h/%b", dump_data, dump_last, held_data, held_last);
          end
        end
        if (dump_ready) begin
          n_checks += 3;
          if (dump_data !== base + 32'(beats)) begin n_fail++; $display("FAIL dump_data[%0d]: got %h exp %h", beats, dump_data, base + 32'(beats)); end
          if (dump_last !== (beats == DUMP_REGS - 1)) begin n_fail++; $display("FAIL dump_last[%0d]: got %b exp %b", beats, dump_last, beats == DUMP_REGS - 1); end
          if (sel !== 5'(beats)) begin n_fail++; $display("FAIL dump_sel[%0d]: got %0d exp %0d", beats, sel, beats); end
          beats++; stalled = 1'b0;
        end else begin
          stalled = 1'b1; held_data = dump_data; held_last = dump_last;
        end
      end
      tick();
      cyc++;
    end
    dump_ready = 1'b0; halt_req = 1'b0; run_req = 1'b0; step_req = 1'b0;
    repeat (2) @(negedge clk);
    n_checks += 5;
    if (beats != DUMP_REGS)        begin n_fail++; $display("FAIL dump_beats: got %0d exp %0d", beats, DUMP_REGS); end
    if (halted !== 1'b1)           begin n_fail++; $display("FAIL dump_end_halted: got %b exp 1", halted); end
    if (sel !== 5'd0)              begin n_fail++; $display("FAIL dump_end_sel: got %0d exp 0", sel); end
    if (en_hi != e0)               begin n_fail++; $display("FAIL dump_core_en: got %0d exp 0", en_hi - e0); end
    if (instr_count !== exp_count) begin n_fail++; $display("FAIL dump_count: got %0d exp %0d", instr_count, exp_count); end
    tick();
  endtask

  task automatic test_reset_mid_dump();
    int acc, cyc;
    acc = 0; cyc = 0;
    dbg_base = 32'h0000_00A0;
    dump_req = 1'b1; tick(); dump_req = 1'b0;
    while (cyc < 100) begin
      @(negedge clk);
      if (dump_valid && acc == 7) break;
      if (dump_valid) begin dump_ready = 1'b1; acc++; end
      else dump_ready = 1'b0;
      cyc++;
    end
    dump_ready = 1'b0;
    n_checks += 2;
    if (!(dump_valid === 1'b1 && acc == 7)) begin n_fail++; $display("FAIL rmd_reach_i7: got valid=%b acc=%0d exp 1/7", dump_valid, acc); end
    if (sel !== 5'd7)              begin n_fail++; $display("FAIL rmd_sel_pre: got %0d exp 7", sel); end
    #2 rst_n = 1'b0;
    #1;
    n_checks += 7;
    if (halted !== 1'b1)           begin n_fail++; $display("FAIL rmd_halted: got %b exp 1", halted); end
    if (sel !== 5'd0)              begin n_fail++; $display("FAIL rmd_sel: got %0d exp 0", sel); end
    if (dump_valid !== 1'b0)       begin n_fail++; $display("FAIL rmd_valid: got %b exp 0", dump_valid); end
    if (dump_last !== 1'b0)        begin n_fail++; $display("FAIL rmd_last: got %b exp 0", dump_last); end
    if (dump_data !== 32'h0)       begin n_fail++; $display("FAIL rmd_data: got %h exp 0", dump_data); end
    if (core_en !== 1'b0)          begin n_fail++; $display("FAIL rmd_core_en: got %b exp 0", core_en); end
    if (instr_count !== '0)        begin n_fail++; $display("FAIL rmd_count: got %0d exp 0", instr_count); end
    exp_count = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks += 2;
    if (halted !== 1'b1 || dump_valid !== 1'b0) begin n_fail++; $display("FAIL rmd_after: got halted=%b valid=%b exp 1/0", halted, dump_valid); end
    if (sel !== 5'd0)              begin n_fail++; $display("FAIL rmd_after_sel: got %0d exp 0", sel); end
    tick();
  endtask

`ifdef CRC_BREAKPOINT_EN
  task automatic test_breakpoint();
    int cyc;
    bp_addr = 32'h10;
    cyc = 0;
    run_req = 1'b1; tick(); run_req = 1'b0;
    while (!halted && cyc < 20) begin @(negedge clk); cyc++; end
    @(negedge clk);
    // four instructions at 0x0..0xC retire before the stop at 0x10
    exp_count = exp_count + 4;
    n_checks += 5;
    if (!halted)                   begin n_fail++; $display("FAIL bp_timeout: got halted=%b exp 1", halted); end
    if (instr_count !== exp_count) begin n_fail++; $display("FAIL bp_count: got %0d exp %0d", instr_count, exp_count); end
    if (bp_hit !== 1'b1)           begin n_fail++; $display("FAIL bp_hit_set: got %b exp 1", bp_hit); end
    if (pc !== 32'h10)             begin n_fail++; $display("FAIL bp_pc: got %h exp 10", pc); end
    if (core_en !== 1'b0)          begin n_fail++; $display("FAIL bp_core_en: got %b exp 0", core_en); end
    tick();
    run_req = 1'b1; tick(); run_req = 1'b0;
    @(negedge clk);
    n_checks += 2;
    if (core_en !== 1'b1)          begin n_fail++; $display("FAIL bp_resume_en: got %b exp 1", core_en); end
    if (bp_hit !== 1'b0)           begin n_fail++; $display("FAIL bp_hit_clear: got %b exp 0", bp_hit); end
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    @(negedge clk);
    exp_count = exp_count + 1;
    n_checks += 2;
    if (pc !== 32'h14)             begin n_fail++; $display("FAIL bp_resume_pc: got %h exp 14", pc); end
    if (instr_count !== exp_count) begin n_fail++; $display("FAIL bp_resume_count: got %0d exp %0d", instr_count, exp_count); end
    bp_addr = 32'hFFFF_FFF0;
    tick();
  endtask
`endif

  initial begin
    dbg_base = 32'h0000_00A0;
    test_reset();
    test_step();
    test_run(10);
    test_run(int'($urandom_range(3, 25)));
    test_priority();
    test_dump(32'h0000_00A0);
    test_dump($urandom);
    test_run(int'($urandom_range(1, 8)));
    test_reset_mid_dump();
`ifdef CRC_BREAKPOINT_EN
    test_breakpoint();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
